// File: rtl/fib_requester.sv
// Valid/ready front end for one fib core: issues a single-cycle go, waits for
// done (or a timeout) and holds the captured result until the consumer takes it.
module fib_requester #(
  parameter int INPUT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_n,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUTPUT_WIDTH-1:0] rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_timeout,
  output logic                    fib_go,
  output logic [INPUT_WIDTH-1:0]  fib_n,
  input  logic [OUTPUT_WIDTH-1:0] fib_result,
  input  logic                    fib_overflow,
  input  logic                    fib_done,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    req_count,
  output logic [CNT_WIDTH-1:0]    to_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic          w_accept, w_done_hit, w_to_hit;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_done_hit = 1'b0;
    w_to_hit   = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) begin
        w_accept = 1'b1;
        w_next   = S_ISSUE;
      end
      S_ISSUE:  w_next = S_SETTLE;
      // done is ignored here: the core may still be clearing a stale done
      S_SETTLE: w_next = S_WAIT;
      S_WAIT: begin
        if (fib_done) begin
          w_done_hit = 1'b1;
          w_next     = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && r_tcnt == TO_LAST) begin
          w_to_hit = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_tcnt       <= '0;
      fib_go       <= 1'b0;
      fib_n        <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_timeout  <= 1'b0;
      req_count    <= '0;
      to_count     <= '0;
    end else begin
      r_state   <= w_next;
      fib_go    <= w_accept;
      rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        fib_n <= req_n;
        if (req_count != '1) req_count <= req_count + CNT_WIDTH'(1);
      end
      // counter covers SETTLE+WAIT; cleared while in ISSUE so SETTLE sees 0
      if (r_state == S_ISSUE)
        r_tcnt <= '0;
      else if (r_state == S_SETTLE || r_state == S_WAIT)
        r_tcnt <= r_tcnt + TW'(1);
      if (w_done_hit) begin
        rsp_result   <= fib_result;
        rsp_overflow <= fib_overflow;
        rsp_timeout  <= 1'b0;
      end else if (w_to_hit) begin
        rsp_result   <= '0;
        rsp_overflow <= 1'b0;
        rsp_timeout  <= 1'b1;
        if (to_count != '1) to_count <= to_count + CNT_WIDTH'(1);
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fib_requester.sv
// Directed bench: requester paired with a behavioural fib core, responses
// checked against a scoreboard queue, core-side protocol watched every cycle.
module tb_fib_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  req_n, fib_n;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_timeout, fib_go, busy;
  logic [31:0] fib_result = '0;
  logic        fib_overflow = 1'b0;
  logic        fib_done = 1'b0;
  logic [2:0]  req_count, to_count;

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        t;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int cyc = 0, go_pulses = 0;
  int c_lat = 3, c_cnt = 0;
  bit c_hang = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fib_requester #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32), .TIMEOUT_CYCLES(16), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout), .fib_go(fib_go), .fib_n(fib_n),
    .fib_result(fib_result), .fib_overflow(fib_overflow), .fib_done(fib_done), .busy(busy),
    .req_count(req_count), .to_count(to_count));

  function automatic longint unsigned fib(input int n);
    longint unsigned a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  // core model: go clears done, done rises c_lat cycles later (never if hung)
  always @(posedge clk) begin
    if (fib_go) begin
      fib_done <= 1'b0;
      c_cnt    <= c_hang ? 0 : c_lat;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        fib_done     <= 1'b1;
        fib_result   <= 32'(fib(int'(fib_n)));
        fib_overflow <= (fib(int'(fib_n)) > 64'h0000_0000_FFFF_FFFF);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       p_go = 0, p_done = 0, p_busy = 0;
  logic [5:0] p_n = '0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (fib_go) go_pulses++;
      if (p_go) chk("go_single_cycle", fib_go, 0);
      if (fib_done && !p_done) chk("go_low_before_done", p_go, 0);
      if (busy && p_busy) chk("fib_n_stable", fib_n, p_n);
    end
    p_go = fib_go; p_done = fib_done; p_busy = busy; p_n = fib_n;
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst === 1'b1 && rsp_valid && rsp_ready) begin
      chk("rsp_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_result", rsp_result, e.r);
        chk("rsp_overflow", rsp_overflow, e.o);
        chk("rsp_timeout", rsp_timeout, e.t);
      end
    end
  end

  task automatic send(input logic [5:0] n, input logic [31:0] r, input logic o,
                      input logic t, input bit push);
    int k = 0;
    req_n = n;
    req_valid = 1'b1;
    if (push) q.push_back('{r: r, o: o, t: t});
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    chk("accept_bound", k < 200, 1);
    @(negedge clk);
    chk("ready_low_busy", req_ready, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || busy) && k < 500) begin @(negedge clk); k++; end
    chk("idle_bound", k < 500, 1);
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
    chk("rsp_bound", k < 200, 1);
  endtask

  initial begin
    int g0, t0;
    rst = 1'b0; req_valid = 1'b0; req_n = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_go", fib_go, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fib_n", fib_n, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_counts", {req_count, to_count}, 0);
    rst = 1'b1;
    @(negedge clk);

    // single request
    g0 = go_pulses;
    send(6'd10, 32'd55, 0, 0, 1);
    req_valid = 1'b0;
    wait_idle();
    chk("one_go_pulse", go_pulses - g0, 1);
    chk("req_count_1", req_count, 1);

    // back-to-back with req_valid held
    send(6'd0, 32'd0, 0, 0, 1);
    send(6'd1, 32'd1, 0, 0, 1);
    send(6'd2, 32'd1, 0, 0, 1);
    send(6'd20, 32'd6765, 0, 0, 1);
    req_valid = 1'b0;
    wait_idle();
    chk("req_count_5", req_count, 5);

    // overflow with backpressure; fib(60) mod 2^32 = 1820529360
    rsp_ready = 1'b0;
    send(6'd60, 32'd1820529360, 1, 0, 1);
    req_valid = 1'b0;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 32'd1820529360);
      chk("bp_flags", {rsp_overflow, rsp_timeout}, 2'b10);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("req_count_6", req_count, 6);

    // timeout: 16 cycles in SETTLE+WAIT, rsp_valid one cycle after ISSUE + 16
    c_hang = 1;
    send(6'd5, 32'd0, 0, 1, 1);
    req_valid = 1'b0;
    t0 = cyc;
    wait_rsp();
    chk("timeout_latency", cyc - t0, 17);
    wait_idle();
    c_hang = 0;
    chk("to_count_1", to_count, 1);
    chk("req_count_7", req_count, 7);

    // counter saturation at all-ones
    send(6'd47, 32'd2971215073, 0, 0, 1);
    req_valid = 1'b0;
    wait_idle();
    chk("req_count_sat", req_count, 7);
    chk("to_count_hold", to_count, 1);

    // reset in the middle of WAIT abandons the transaction
    c_lat = 12;
    send(6'd10, 32'd0, 0, 0, 0);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_go", fib_go, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_fib_n", fib_n, 0);
    chk("mid_rst_counts", {req_count, to_count}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    c_lat = 3;
    send(6'd10, 32'd55, 0, 0, 1);
    req_valid = 1'b0;
    wait_idle();
    chk("post_rst_req_count", req_count, 1);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
